exp_src_arbiter: RTL
====================

Name: exp_src_arbiter

Overview:
- Sits directly upstream of CP0 and drives its ExpSrc0/ExpSrc1/ExpSrc2 inputs.
- Synchronises three asynchronous exception/interrupt request lines and rising-edge detects them.
- Latches each edge as pending, applies a software mask, and issues one request at a time in fixed priority.
- Holds the issued request until CP0 accepts it (HasExp), then waits for ERET before issuing the next one.

Parameters:
- SYNC_STAGES, 2: synchroniser flop depth per request line; legal range is 2 or more.
- MASK_RST, 3'b111: mask register value after reset; 1 means the source is enabled.
- TIMEOUT, 16: cycle limit in REQ; used only when EXP_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  3  raw asynchronous request lines; bit 0 has the highest priority.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  3  new mask value.
- exp_block  in  1  CP0 ExpBlock; while high, no new request is issued.
- has_exp  in  1  CP0 HasExp; acceptance of the issued request.
- is_eret  in  1  CP0 IsEret; the handler is returning.
- exp_src  out  3  one-hot request vector to CP0; bit i drives ExpSrci.
- pending  out  3  latched pending bits, before masking.
- mask  out  3  current mask register.
- in_service  out  3  one-hot source currently being serviced (REQ or SERVICE state).
- req_timeout  out  1  one-cycle pulse; present only when EXP_TIMEOUT_EN is defined.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops and edge flops = 0.
  - pending = 0, mask = MASK_RST, exp_src = 0, in_service = 0, req_timeout = 0, state = IDLE.
  - Reset asserted mid-operation drops any in-flight request immediately.
- Sync and edge detect: per bit, a SYNC_STAGES-deep flop chain plus one delay flop; edge = last stage & ~delay flop.
- Pending register:
  - pending[i] is set on edge[i] and cleared on acceptance of source i.
  - Set and clear of the same bit in the same cycle: set wins, so the new edge is not lost.
  - A level held high produces exactly one pending set.
- Mask register: mask_we=1 loads mask_wdata on the next edge. Masking gates arbitration only. A masked bit stays pending and is issued once unmasked. Mask writes do not affect a source already in REQ or SERVICE.
- Eligibility: elig = pending & mask. Selection is the lowest set index of elig.
- State machine (registered outputs), states IDLE, REQ, SERVICE:
  - IDLE: if exp_block=0 and elig!=0, go to REQ; exp_src and in_service are loaded one-hot with the selected source. Otherwise stay; exp_src=0.
  - REQ: exp_src is held stable and is not re-arbitrated, even if a higher-priority source becomes pending. On has_exp=1: clear pending[sel], set exp_src=0, go to SERVICE.
  - SERVICE: exp_src=0, in_service held. On is_eret=1: in_service=0, go to IDLE. A new request can issue at the earliest one cycle after returning to IDLE.
  - has_exp outside REQ is ignored. is_eret outside SERVICE is ignored.
- Latency, counting the first edge that samples irq_in high as edge 1 (SYNC_STAGES=2):
  - Edge 2: edge detect goes high.
  - Edge 3: pending set.
  - Edge 4: exp_src asserted.
  - In general exp_src rises at edge SYNC_STAGES+2 when IDLE and unblocked.
- exp_block rising while in REQ does not withdraw the request.
- At most one exp_src bit is high in any cycle.

Optional Feature:
- Macro: EXP_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ.
  - If has_exp has not been seen after TIMEOUT cycles in REQ: exp_src=0, in_service=0, go to IDLE. pending[sel] stays set, and req_timeout pulses high for one cycle.
  - has_exp in the same cycle as expiry takes precedence; the request is accepted normally.
  - The counter clears on every entry to REQ.
- Not defined: REQ waits indefinitely for has_exp. The req_timeout port and the counter are absent.

Test Plan:
- Reset and single request: after reset, mask=3'b111 and all outputs 0. Raise irq_in=3'b010 and hold it high. exp_src=3'b010 at edge 4, pending=3'b010. Assert has_exp for 1 cycle: exp_src=0, pending=0, in_service=3'b010. Pulse is_eret: in_service=0, and no reissue while irq_in stays high.
- Priority and no preemption: irq_in=3'b110 at the same time, giving exp_src=3'b010. Then raise irq_in[0] while in REQ: exp_src stays 3'b010. After accept and ERET, exp_src=3'b001 next, then 3'b100 after its own accept and ERET.
- Masking: write mask=3'b011, then raise irq_in[2]. pending=3'b100 and exp_src stays 0 for 20 cycles. Write mask=3'b111: exp_src=3'b100 one cycle after the mask update.
- Block and set/clear collision:
  - With exp_block=1 and pending[1]=1, exp_src stays 0. Drop exp_block: exp_src=3'b010 on the next edge.
  - Toggle irq_in[1] so its edge lands in the has_exp cycle: pending[1] remains 1 after acceptance.
- Async reset mid-REQ: with exp_src=3'b001, pull rst_n low between clock edges. exp_src, pending and in_service go to 0 immediately without waiting for a clock edge, and mask returns to 3'b111.
- EXP_TIMEOUT_EN, TIMEOUT=16: issue a request and never assert has_exp. After 16 REQ cycles, exp_src=0, req_timeout pulses for 1 cycle, and pending is still set. The request reissues on the following IDLE cycle.

Source files
------------

// File: rtl/exp_src_arbiter.sv
// ---------------------------------------------------------------------------
// exp_src_arbiter
//
// Purpose:
//   Front end for CP0's ExpSrc0/1/2 inputs. Three asynchronous request lines
//   are synchronised and rising-edge detected. Each edge is latched as
//   pending. A software mask decides which pending bits may be arbitrated.
//   Only one request is issued at a time, in fixed priority (bit 0 highest).
//   An issued request is held until CP0 accepts it with has_exp. The block
//   then waits for is_eret before it arbitrates again.
//
// Optional feature (macro EXP_TIMEOUT_EN):
//   A request left in REQ for TIMEOUT cycles without has_exp is withdrawn.
//   Its pending bit stays set, and req_timeout pulses for one cycle.
//   Without the macro, REQ waits indefinitely. In that build the req_timeout
//   port and the counter do not exist.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth per line (>= 2)
//   MASK_RST     mask value after reset (1 = source enabled)
//   TIMEOUT      REQ cycle limit (used only with EXP_TIMEOUT_EN)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   irq_in       raw asynchronous request lines, bit 0 highest priority
//   mask_we      mask register write strobe
//   mask_wdata   new mask value
//   exp_block    CP0 ExpBlock: no new request is issued while high
//   has_exp      CP0 HasExp: the issued request is accepted
//   is_eret      CP0 IsEret: the handler is returning
//   exp_src      one-hot request vector to CP0
//   pending      latched pending bits (before masking)
//   mask         current mask register
//   in_service   one-hot source in REQ or SERVICE
//   req_timeout  one-cycle timeout pulse (EXP_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module exp_src_arbiter #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] MASK_RST    = 3'b111,
    parameter int         TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] irq_in,
    input  logic       mask_we,
    input  logic [2:0] mask_wdata,
    input  logic       exp_block,
    input  logic       has_exp,
    input  logic       is_eret,
    output logic [2:0] exp_src,
    output logic [2:0] pending,
    output logic [2:0] mask,
`ifdef EXP_TIMEOUT_EN
    output logic       req_timeout,
`endif
    output logic [2:0] in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("exp_src_arbiter: SYNC_STAGES must be 2 or more");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("exp_src_arbiter: TIMEOUT must be 1 or more");
    end

    state_t     state_reg;
    logic [2:0] exp_src_reg;
    logic [2:0] in_service_reg;
    logic [2:0] pending_reg;
    logic [2:0] pending_next;
    logic [2:0] mask_reg;
    logic [2:0] edge_det;
    logic [2:0] elig;
    logic [2:0] sel_onehot;
    logic [2:0] accept_clr;

    // -----------------------------------------------------------------------
    // Per-line synchroniser plus one delay flop for rising-edge detection.
    // -----------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_reg;
        logic                   dly_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_reg <= '0;
                dly_reg  <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in[gi]};
                dly_reg  <= sync_reg[SYNC_STAGES-1];
            end
        end

        assign edge_det[gi] = sync_reg[SYNC_STAGES-1] & ~dly_reg;
    end

    // -----------------------------------------------------------------------
    // Pending bits. An acceptance clears the serviced bit. An edge arriving
    // in the same cycle re-sets it, so that edge is not lost.
    // -----------------------------------------------------------------------
    always_comb begin
        accept_clr = 3'b000;
        if (state_reg == ST_REQ && has_exp) begin
            accept_clr = in_service_reg;
        end
        pending_next = (pending_reg & ~accept_clr) | edge_det;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 3'b000;
        end else begin
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= MASK_RST;
        end else if (mask_we) begin
            mask_reg <= mask_wdata;
        end
    end

    // Lowest set bit of the eligible vector: x & -x isolates it.
    assign elig       = pending_reg & mask_reg;
    assign sel_onehot = elig & (~elig + 3'd1);

    // -----------------------------------------------------------------------
    // Issue state machine. All of its outputs are registered.
    // -----------------------------------------------------------------------
`ifdef EXP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_reg;
    logic             req_timeout_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            exp_src_reg     <= 3'b000;
            in_service_reg  <= 3'b000;
`ifdef EXP_TIMEOUT_EN
            cnt_reg         <= '0;
            req_timeout_reg <= 1'b0;
`endif
        end else begin
`ifdef EXP_TIMEOUT_EN
            req_timeout_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (!exp_block && elig != 3'b000) begin
                        state_reg      <= ST_REQ;
                        exp_src_reg    <= sel_onehot;
                        in_service_reg <= sel_onehot;
`ifdef EXP_TIMEOUT_EN
                        cnt_reg        <= '0;
`endif
                    end else begin
                        exp_src_reg <= 3'b000;
                    end
                end
                ST_REQ: begin
                    // The request is held as issued. It is not re-arbitrated
                    // and is not withdrawn by exp_block.
                    if (has_exp) begin
                        exp_src_reg <= 3'b000;
                        state_reg   <= ST_SERVICE;
                    end
`ifdef EXP_TIMEOUT_EN
                    else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        exp_src_reg     <= 3'b000;
                        in_service_reg  <= 3'b000;
                        state_reg       <= ST_IDLE;
                        req_timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                ST_SERVICE: begin
                    exp_src_reg <= 3'b000;
                    if (is_eret) begin
                        in_service_reg <= 3'b000;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    exp_src_reg    <= 3'b000;
                    in_service_reg <= 3'b000;
                end
            endcase
        end
    end

    assign exp_src    = exp_src_reg;
    assign in_service = in_service_reg;
    assign pending    = pending_reg;
    assign mask       = mask_reg;
`ifdef EXP_TIMEOUT_EN
    assign req_timeout = req_timeout_reg;
`endif

endmodule
